// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// Valid/ready: a transfer happens on a rising edge where valid && ready; once the
// producer raises valid its payload stays stable until that transfer completes.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned non-restoring divider, one quotient bit per cycle,
// built around a single shared adder-subtractor.

module add_sub #(
  parameter int WIDTH     = 33,
  parameter int ARCH      = 0,
  parameter int GRP_WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);
  logic [WIDTH-1:0] w_b;
  logic             w_cin;

  // With sub=1, ci acts as a borrow-in: a - b - ci.
  assign w_b   = b ^ {WIDTH{sub}};
  assign w_cin = sub ^ ci;

  if (ARCH == 0) begin : g_ripple
    assign {co, sum} = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
  end else begin : g_csel
    localparam int NG = (WIDTH + GRP_WIDTH - 1) / GRP_WIDTH;
    logic [NG:0] w_c;
    assign w_c[0] = w_cin;
    for (genvar g = 0; g < NG; g++) begin : g_grp
      localparam int LO = g * GRP_WIDTH;
      localparam int HI = (LO + GRP_WIDTH > WIDTH) ? WIDTH - 1 : LO + GRP_WIDTH - 1;
      localparam int GW = HI - LO + 1;
      logic [GW:0] w_s0;
      logic [GW:0] w_s1;
      assign w_s0 = {1'b0, a[HI:LO]} + {1'b0, w_b[HI:LO]};
      assign w_s1 = {1'b0, a[HI:LO]} + {1'b0, w_b[HI:LO]} + {{GW{1'b0}}, 1'b1};
      assign sum[HI:LO] = w_c[g] ? w_s1[GW-1:0] : w_s0[GW-1:0];
      assign w_c[g+1]   = w_c[g] ? w_s1[GW]     : w_s0[GW];
    end
    assign co = w_c[NG];
  end
endmodule

module seq_divider #(
  parameter int WIDTH     = 32,
  parameter int ARCH      = 0,
  parameter int GRP_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_divider_if.slave bus,
  output logic [1:0]  o_dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic             w_accept;
  logic             w_d_zero;
  logic [WIDTH:0]   w_p_shift;
  logic [WIDTH:0]   w_add_a;
  logic [WIDTH:0]   w_add_b;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic             w_co_unused;

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_d_zero = (bus.divisor == '0);

  // {P,A} << 1; the old sign of P is dropped because P+-D always lands back in range.
  assign w_p_shift = {r_p[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_add_a   = (r_state == S_FIX) ? r_p : w_p_shift;
  assign w_add_b   = {1'b0, r_d};
  assign w_sub     = (r_state == S_CALC) && !r_p[WIDTH];

  add_sub #(
    .WIDTH     (WIDTH + 1),
    .ARCH      (ARCH),
    .GRP_WIDTH (GRP_WIDTH)
  ) u_add_sub (
    .a   (w_add_a),
    .b   (w_add_b),
    .sub (w_sub),
    .ci  (1'b0),
    .sum (w_sum),
    .co  (w_co_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_d_zero ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p   <= '0;
      r_a   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_d <= bus.divisor;
            r_p <= '0;
            r_a <= bus.dividend;
            if (w_d_zero) begin
              r_q   <= '1;
              r_r   <= bus.dividend;
              r_dbz <= 1'b1;
              r_cnt <= '0;
            end else begin
              r_dbz <= 1'b0;
              r_cnt <= CW'(WIDTH - 1);
            end
          end
        end
        S_CALC: begin
          r_p <= w_sum;
          r_a <= {r_a[WIDTH-2:0], ~w_sum[WIDTH]};
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          if (r_p[WIDTH]) r_p <= w_sum;
          r_q <= r_a;
          r_r <= r_p[WIDTH] ? w_sum[WIDTH-1:0] : r_p[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.quotient    = r_q;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = r_dbz;
  assign o_dbg_state     = r_state;
endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned integer divider for the divider datapath. It computes one quotient bit per cycle using non-restoring division and reuses the team's `add_sub` adder-subtractor, with its ARCH and GRP_WIDTH passed through. Operands enter and results leave through valid/ready handshakes, so the block can sit between a register-file read stage and a writeback stage with arbitrary backpressure.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width in bits; must be ≥ 2.
- `ARCH`, default 0: adder architecture select, forwarded to `add_sub`.
- `GRP_WIDTH`, default 4: adder group width, forwarded to `add_sub`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  divider can accept operands.
- `dividend`  in  WIDTH  unsigned dividend N.
- `divisor`  in  WIDTH  unsigned divisor D.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `quotient`  out  WIDTH  floor(N/D).
- `remainder`  out  WIDTH  N mod D.
- `div_by_zero`  out  1  the result belongs to an operation with D == 0.

## Operation
- States are IDLE, CALC, FIX and DONE. The FSM leaves reset in IDLE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE). Both are decoded from registered state only.
- Accept: when `in_valid` && `in_ready` are high at a rising edge, the block captures D, clears partial remainder P (WIDTH+1 bits, signed) to 0, and loads A ← N.
  - If D == 0: quotient ← all ones, remainder ← N, `div_by_zero` ← 1, and the FSM goes to DONE.
  - Otherwise: `div_by_zero` ← 0, iteration counter ← WIDTH−1, and the FSM goes to CALC.
- CALC, one iteration per cycle:
  - Shift {P,A} left by 1.
  - If the old P ≥ 0, P ← P_shifted − {0,D}; otherwise P ← P_shifted + {0,D}.
  - The new quotient bit is ~P_new[WIDTH]. It shifts into the LSB of A, which becomes the quotient.
  - When the counter reaches 0, go to FIX; otherwise decrement the counter.
- FIX: if P < 0, P ← P + {0,D}; otherwise P is unchanged. Then quotient ← A, remainder ← P[WIDTH−1:0], and the FSM goes to DONE.
- All additions and subtractions use a single `add_sub` instance of width WIDTH+1:
  - `sub` = 1 selects subtract.
  - `ci` is tied to 0.
  - `co` is unused.
  - No other adder is used in the P path.
- DONE: outputs hold stable until `out_valid` && `out_ready`, then the FSM goes to IDLE. In DONE, `in_ready` = 0, even when `out_ready` = 1 in the same cycle.
- Operands are sampled only at accept. Later changes on `dividend`/`divisor` have no effect.

## Timing
- Reset, asserted at any time including mid-CALC:
  - State goes to IDLE. `in_ready` = 1, `out_valid` = 0, `quotient` = 0, `remainder` = 0, `div_by_zero` = 0.
  - P, A, D and the counter clear to 0.
  - Any in-flight operation is discarded; no partial result is ever presented.
- Release of `rst_n` is synchronized by the integrating top level. The block accepts on the first rising edge where `rst_n` is high.
- Accept edge = cycle 0. Normal latency:
  - CALC occupies cycles 1..WIDTH.
  - FIX is cycle WIDTH+1.
  - `out_valid` rises at cycle WIDTH+2.
- Divide-by-zero latency: `out_valid` rises at cycle 1.
- Throughput without backpressure: one operation per WIDTH+3 cycles. With `out_ready` held high, IDLE lasts at least one cycle between operations.
- Backpressure is unbounded. `quotient`, `remainder` and `div_by_zero` must not change while `out_valid` = 1 and `out_ready` = 0.
- The critical path is one `add_sub` plus the P mux. No combinational path runs from any input to any output.

## Test plan
- WIDTH=8, N=100, D=7 → `out_valid` at cycle 10; quotient=14, remainder=2, `div_by_zero`=0.
- WIDTH=8, with N=255,D=1 then N=5,D=9 back to back and `out_ready`=1 → q=255,r=0, then q=0,r=5. The second accept occurs exactly one IDLE cycle after the first result handshake.
- WIDTH=8, N=0x5A, D=0 → `out_valid` at cycle 1; quotient=0xFF, remainder=0x5A, `div_by_zero`=1.
- WIDTH=32, N=0xFFFFFFFF, D=0x10000, `out_ready` held low for 20 cycles after `out_valid` → q=0xFFFF, r=0xFFFF held constant; `in_ready`=0 throughout; IDLE on the edge after `out_ready` rises.
- WIDTH=32, `rst_n` pulsed low at cycle 10 of CALC → all outputs at reset values immediately (asynchronously), `in_ready`=1 after release. A following N=1000, D=3 returns q=333, r=1.
- WIDTH=16 and WIDTH=32 across ARCH values, 10k random operands including D=1, D=N, D>N and D=2^k, with random `in_valid`/`out_ready` → every result matches the reference model N/D, N%D. No result is dropped or duplicated.
